// File: rtl/elevator_scan_ctrl.sv
// Single-car elevator controller using SCAN scheduling: serves every pending
// floor in the current direction and only then reverses.
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS   = 10,
  parameter int FLOOR_W      = 4,
  parameter int TRAVEL_TICKS = 10000000,
  parameter int DOOR_TICKS   = 5000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic                  arrived,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [DW-1:0]      DOOR_LAST   = DW'(DOOR_TICKS - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic               DIR_UP      = 1'b0;
  localparam logic               DIR_DOWN    = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DOOR_OPEN} state_t;

  state_t                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [TW-1:0]         travel_cnt_q, travel_cnt_d;
  logic [DW-1:0]         door_cnt_q, door_cnt_d;
  logic                  arrived_q, arrived_d;

  logic [NUM_FLOORS-1:0] req_bit, pend_all;
  logic                  req_here, absorb, above, below;

  // req_valid is a single-cycle strobe with no back-pressure: every strobe
  // with an in-range floor is taken on the edge that samples it.
  always_comb begin
    req_bit = '0;
    if (req_valid && (int'(req_floor) < NUM_FLOORS)) req_bit[req_floor] = 1'b1;
    req_here = req_valid && (req_floor == floor_q);
    absorb   = req_here && ((state_q == S_IDLE) || (state_q == S_DOOR_OPEN));
    pend_all = pending_q | (absorb ? '0 : req_bit);
    above    = 1'b0;
    below    = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pend_all[i] && (i > int'(floor_q))) above = 1'b1;
      if (pend_all[i] && (i < int'(floor_q))) below = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    floor_d      = floor_q;
    pending_d    = pend_all;
    travel_cnt_d = travel_cnt_q;
    door_cnt_d   = door_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (absorb)                 state_d = S_DOOR_OPEN;
        else if (above && below)    state_d = (dir_q == DIR_UP) ? S_MOVE_UP : S_MOVE_DOWN;
        else if (above)             state_d = S_MOVE_UP;
        else if (below)             state_d = S_MOVE_DOWN;
      end
      S_MOVE_UP: begin
        if (floor_q == TOP_FLOOR) begin
          state_d = S_IDLE;
        end else if (travel_cnt_q == TRAVEL_LAST) begin
          travel_cnt_d = '0;
          floor_d      = floor_q + 1'b1;
          if (pend_all[floor_d]) begin
            state_d            = S_DOOR_OPEN;
            pending_d[floor_d] = 1'b0;
          end else if (floor_d == TOP_FLOOR) begin
            state_d = S_IDLE;
          end
        end else begin
          travel_cnt_d = travel_cnt_q + 1'b1;
        end
      end
      S_MOVE_DOWN: begin
        if (floor_q == '0) begin
          state_d = S_IDLE;
        end else if (travel_cnt_q == TRAVEL_LAST) begin
          travel_cnt_d = '0;
          floor_d      = floor_q - 1'b1;
          if (pend_all[floor_d]) begin
            state_d            = S_DOOR_OPEN;
            pending_d[floor_d] = 1'b0;
          end else if (floor_d == '0) begin
            state_d = S_IDLE;
          end
        end else begin
          travel_cnt_d = travel_cnt_q + 1'b1;
        end
      end
      S_DOOR_OPEN: begin
        if (req_here) begin
          door_cnt_d = '0;
        end else if (door_cnt_q == DOOR_LAST) begin
          // Keep sweeping in dir while work remains that way, then reverse.
          if (dir_q == DIR_UP) begin
            if (above)      state_d = S_MOVE_UP;
            else if (below) state_d = S_MOVE_DOWN;
            else            state_d = S_IDLE;
          end else begin
            if (below)      state_d = S_MOVE_DOWN;
            else if (above) state_d = S_MOVE_UP;
            else            state_d = S_IDLE;
          end
        end else begin
          door_cnt_d = door_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_MOVE_UP)   dir_d = DIR_UP;
    if (state_d == S_MOVE_DOWN) dir_d = DIR_DOWN;
    if (state_d != state_q) begin
      travel_cnt_d = '0;
      door_cnt_d   = '0;
    end
    arrived_d = (state_d == S_DOOR_OPEN) && (state_q != S_DOOR_OPEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dir_q        <= DIR_UP;
      floor_q      <= '0;
      pending_q    <= '0;
      travel_cnt_q <= '0;
      door_cnt_q   <= '0;
      arrived_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      floor_q      <= floor_d;
      pending_q    <= pending_d;
      travel_cnt_q <= travel_cnt_d;
      door_cnt_q   <= door_cnt_d;
      arrived_q    <= arrived_d;
    end
  end

  assign current_floor = floor_q;
  assign pending       = pending_q;
  assign arrived       = arrived_q;
  assign moving_up     = (state_q == S_MOVE_UP);
  assign moving_down   = (state_q == S_MOVE_DOWN);
  assign door_open     = (state_q == S_DOOR_OPEN);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl: arrival floors are queued in expected
// SCAN order and popped by a monitor whenever the car reports an arrival.
module tb_elevator_scan_ctrl;

  localparam int NF = 10;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [FW-1:0] req_floor = '0;
  logic [FW-1:0] current_floor;
  logic          moving_up, moving_down, door_open, arrived;
  logic [NF-1:0] pending;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] exp_f;

  elevator_scan_ctrl #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_TICKS(4), .DOOR_TICKS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_floor(req_floor),
    .current_floor(current_floor), .moving_up(moving_up), .moving_down(moving_down),
    .door_open(door_open), .arrived(arrived), .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int f);
    req_valid = 1'b1;
    req_floor = FW'(f);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_floor(input int f);
    int n = 0;
    while (current_floor != FW'(f) && n < 200) begin tick(); n++; end
    chk("wait_floor", current_floor, f);
  endtask

  task automatic wait_door();
    int n = 0;
    while (!door_open && n < 200) begin tick(); n++; end
    chk("wait_door", door_open, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin tick(); n++; end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((moving_up || moving_down || door_open) && n < 100) begin tick(); n++; end
    chk("idle", {moving_up, moving_down, door_open}, 0);
  endtask

  // Scoreboard monitor: each arrival pulse must match the head of exp_q.
  always @(negedge clk) begin
    if (rst_n && arrived) begin
      if (exp_q.size() == 0) begin
        chk("arrival_unexpected", current_floor, 32'hFFFF_FFFF);
      end else begin
        exp_f = exp_q.pop_front();
        chk("arrival_floor", current_floor, exp_f);
      end
    end
    if (moving_up || moving_down) chk("move_excl", moving_up & moving_down, 0);
  end

  initial begin
    // Reset values, asynchronous assertion
    #3;
    chk("rst_floor", current_floor, 0);
    chk("rst_pending", pending, 0);
    chk("rst_outs", {moving_up, moving_down, door_open, arrived}, 0);
    tick();
    tick();

    // Basic trip to floor 3, request in first cycle after reset release
    rst_n = 1'b1;
    exp_q.push_back(4'd3);
    req(3);
    chk("t1_moving_up", moving_up, 1);
    chk("t1_pending", pending, 10'h008);
    repeat (3) tick();
    chk("t1_floor0_hold", current_floor, 0);
    tick();
    chk("t1_floor1", current_floor, 1);
    repeat (4) tick();
    chk("t1_floor2", current_floor, 2);
    repeat (4) tick();
    chk("t1_floor3", current_floor, 3);
    chk("t1_door_arr", {door_open, arrived}, 2'b11);
    chk("t1_pend_clr", pending, 0);
    tick();
    chk("t1_door_c2", {door_open, arrived}, 2'b10);
    tick();
    chk("t1_door_c3", door_open, 1);
    tick();
    chk("t1_idle", {moving_up, moving_down, door_open}, 0);
    chk("t1_pend_end", pending, 0);
    wait_drain();

    // SCAN tie: at floor 5 with dir up, requests 2 and 7 -> 7 first
    exp_q.push_back(4'd5);
    req(5);
    wait_door();
    chk("t2_at5", current_floor, 5);
    req(2);
    req(7);
    chk("t2_pending", pending, 10'h084);
    tick();
    chk("t2_go_up", moving_up, 1);
    exp_q.push_back(4'd7);
    exp_q.push_back(4'd2);
    wait_drain();
    wait_idle();
    chk("t2_end_floor", current_floor, 2);
    chk("t2_end_pend", pending, 0);

    // Intermediate stop: 2 -> 6 with 4 requested on the way
    exp_q.push_back(4'd6);
    req(6);
    wait_floor(3);
    exp_q.push_front(4'd4);
    req(4);
    wait_door();
    chk("t3_stop4", current_floor, 4);
    repeat (3) tick();
    chk("t3_continue", moving_up, 1);
    wait_drain();
    wait_idle();
    chk("t3_end_floor", current_floor, 6);

    // Door at the current floor, re-request extension, out-of-range request
    exp_q.push_back(4'd0);
    req(0);
    wait_drain();
    wait_idle();
    exp_q.push_back(4'd0);
    req(0);
    chk("t4_door_now", {door_open, arrived}, 2'b11);
    chk("t4_no_pend", pending, 0);
    tick();
    chk("t4_door_c2", door_open, 1);
    tick();
    chk("t4_door_c3", door_open, 1);
    tick();
    chk("t4_door_closed", door_open, 0);
    exp_q.push_back(4'd0);
    req(0);
    tick();
    req(0);
    chk("t4_restart_c1", {door_open, arrived}, 2'b10);
    tick();
    chk("t4_restart_c2", door_open, 1);
    tick();
    chk("t4_restart_c3", door_open, 1);
    tick();
    chk("t4_restart_end", door_open, 0);
    chk("t4_pend", pending, 0);
    req(12);
    chk("t4_oor_pend", pending, 0);
    repeat (3) tick();
    chk("t4_oor_idle", {moving_up, moving_down, door_open, current_floor}, 0);
    wait_drain();

    // Request for the departing floor is latched and served after reversal
    exp_q.push_back(4'd3);
    req(3);
    exp_q.push_back(4'd0);
    req(0);
    chk("t5_pending", pending, 10'h009);
    chk("t5_no_reverse", moving_up, 1);
    wait_drain();
    wait_idle();
    chk("t5_end", {current_floor, pending}, 0);

    // Reset mid-travel between floors 4 and 5 with 8 and 1 pending
    req(8);
    wait_floor(4);
    req(1);
    chk("t6_pending", pending, 10'h102);
    chk("t6_moving", moving_up, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {moving_up, moving_down, door_open, arrived}, 0);
    chk("t6_rst_state", {current_floor, pending}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("t6_idle_after", {moving_up, moving_down, door_open}, 0);
    chk("t6_floor_pend", {current_floor, pending}, 0);
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
